// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter: FSM state encoding and owner codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone requester wins outright; on a tie the
// port that did not win last time is chosen. Purely combinational.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_t     i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_last == OWN_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch (I) and load/store (D) requesters:
// round-robin grant, one outstanding transaction, response demux and timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_next;
  owner_t              r_owner;
  owner_t              r_last_owner;
  owner_t              w_winner;
  logic [CNT_W-1:0]    r_count;
  logic                r_m_req;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [BE_W-1:0]     r_m_be;
  logic [1:0]          w_arb_gnt;
  logic [1:0]          w_grant;
  logic                w_resp_valid;
  logic                w_resp_err;
  logic [DATA_W-1:0]   w_resp_data;

  rr_arb2 u_rr_arb2 (
    .i_req  ({d_req, i_req}),
    .i_last (r_last_owner),
    .o_gnt  (w_arb_gnt)
  );

  // Grants only leave the block while idle and out of reset.
  assign w_grant  = (r_state == ST_IDLE && rst) ? w_arb_gnt : 2'b00;
  assign w_winner = w_grant[1] ? OWN_D : OWN_I;
  assign i_gnt    = w_grant[0];
  assign d_gnt    = w_grant[1];

  always_comb begin
    w_state_next = r_state;
    w_resp_valid = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (m_gnt) begin
          if (m_rvalid) begin
            w_state_next = ST_IDLE;
            w_resp_valid = 1'b1;
            w_resp_data  = m_rdata;
          end else begin
            w_state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (m_rvalid) begin
          w_state_next = ST_IDLE;
          w_resp_valid = 1'b1;
          w_resp_data  = m_rdata;
        end else if (r_count == CNT_LAST) begin
          w_state_next = ST_IDLE;
          w_resp_valid = 1'b1;
          w_resp_err   = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign i_rvalid = w_resp_valid && (r_owner == OWN_I);
  assign i_err    = w_resp_err && (r_owner == OWN_I);
  assign i_rdata  = i_rvalid ? w_resp_data : '0;
  assign d_rvalid = w_resp_valid && (r_owner == OWN_D);
  assign d_err    = w_resp_err && (r_owner == OWN_D);
  assign d_rdata  = d_rvalid ? w_resp_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_D;
      r_last_owner <= OWN_D;
      r_count      <= '0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_be       <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_m_req      <= 1'b1;
            if (w_grant[1]) begin
              r_m_we    <= d_we;
              r_m_addr  <= d_addr;
              r_m_wdata <= d_wdata;
              r_m_be    <= d_be;
            end else begin
              r_m_we    <= 1'b0;
              r_m_addr  <= i_addr;
              r_m_wdata <= '0;
              r_m_be    <= '1;
            end
          end
        end
        ST_REQ: begin
          if (m_gnt) begin
            r_m_req <= 1'b0;
            r_count <= '0;
          end
        end
        ST_RESP: begin
          if (r_count != CNT_LAST) r_count <= r_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_be    = r_m_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queued requesters, a variable-latency
// memory model and a monitor that logs grants and responses per cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int TO = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } mreq_t;

  typedef struct packed {
    logic          port;
    logic          err;
    logic [DW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic i_req, i_gnt, i_rvalid, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [BW-1:0] d_be;
  logic m_req, m_we, m_gnt, m_rvalid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [BW-1:0] m_be;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;

  logic [AW-1:0] iq[$];
  mreq_t         dq[$];
  resp_t         exp_q[$], obs_q[$];
  int            obs_cyc[$];
  logic          gnt_port[$];
  int            gnt_cyc[$];
  mreq_t         mexp_q[$], mobs_q[$];

  int    gnt_delay  = 0;
  int    resp_delay = 1;
  bit    withhold   = 1'b0;
  bit    inject_rv  = 1'b0;
  bit    pend       = 1'b0;
  int    gcnt       = 0;
  int    rcnt       = 0;
  int    unstable   = 0;
  logic [DW-1:0] pend_data;
  mreq_t first_seen;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 64'h40) return 64'hDEAD;
    return {a[31:0], ~a[31:0]};
  endfunction

  // Fetch requester: holds i_req with the head address until granted.
  initial begin
    i_req = 1'b0; i_addr = '0;
    forever begin
      @(negedge clk);
      if (iq.size() > 0) begin i_req = 1'b1; i_addr = iq[0]; end
      else i_req = 1'b0;
      #1;
      if (i_req === 1'b1 && i_gnt === 1'b1) void'(iq.pop_front());
    end
  end

  // Data requester.
  initial begin
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    forever begin
      @(negedge clk);
      if (dq.size() > 0) begin d_req = 1'b1; {d_we, d_addr, d_wdata, d_be} = dq[0]; end
      else d_req = 1'b0;
      #1;
      if (d_req === 1'b1 && d_gnt === 1'b1) void'(dq.pop_front());
    end
  end

  // Memory model: accepts after gnt_delay cycles, answers resp_delay cycles later.
  initial begin
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      if (rst !== 1'b1) begin
        pend = 1'b0; gcnt = 0;
      end else if (inject_rv) begin
        m_rvalid = 1'b1; m_rdata = 64'hBAD0_BAD0; inject_rv = 1'b0;
      end else if (pend) begin
        if (rcnt == 0) begin
          pend = 1'b0;
          if (!withhold) begin m_rvalid = 1'b1; m_rdata = pend_data; end
        end else rcnt--;
      end else if (m_req === 1'b1) begin
        if (gcnt == 0) first_seen = {m_we, m_addr, m_wdata, m_be};
        else if ({m_we, m_addr, m_wdata, m_be} !== first_seen) unstable++;
        if (gcnt == gnt_delay) begin
          m_gnt = 1'b1; gcnt = 0;
          mobs_q.push_back({m_we, m_addr, m_wdata, m_be});
          pend_data = mem_val(m_addr);
          if (resp_delay == 0) begin
            if (!withhold) begin m_rvalid = 1'b1; m_rdata = pend_data; end
          end else begin
            pend = 1'b1; rcnt = resp_delay - 1;
          end
        end else gcnt++;
      end
    end
  end

  // Monitor: logs grants and responses, counts protocol violations.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (i_gnt === 1'b1) begin gnt_port.push_back(1'b0); gnt_cyc.push_back(cyc); end
      if (d_gnt === 1'b1) begin gnt_port.push_back(1'b1); gnt_cyc.push_back(cyc); end
      if (i_rvalid === 1'b1) begin obs_q.push_back({1'b0, i_err, i_rdata}); obs_cyc.push_back(cyc); end
      if (d_rvalid === 1'b1) begin obs_q.push_back({1'b1, d_err, d_rdata}); obs_cyc.push_back(cyc); end
      if (i_gnt === 1'b1 && d_gnt === 1'b1) viol++;
      if (i_rvalid === 1'b1 && d_rvalid === 1'b1) viol++;
      if (i_rvalid !== 1'b1 && (i_err !== 1'b0 || i_rdata !== '0)) viol++;
      if (d_rvalid !== 1'b1 && (d_err !== 1'b0 || d_rdata !== '0)) viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    gnt_port.delete(); gnt_cyc.delete(); mexp_q.delete(); mobs_q.delete();
  endtask

  task automatic push_i(input logic [AW-1:0] a);
    iq.push_back(a);
    exp_q.push_back({1'b0, 1'b0, mem_val(a)});
    mexp_q.push_back({1'b0, a, {DW{1'b0}}, {BW{1'b1}}});
  endtask

  task automatic push_d(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be);
    dq.push_back({we, a, wd, be});
    exp_q.push_back({1'b1, 1'b0, mem_val(a)});
    mexp_q.push_back({we, a, wd, be});
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #3;
      if (iq.size() == 0 && dq.size() == 0 && obs_q.size() >= exp_q.size() &&
          m_req !== 1'b1 && !pend) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    total++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err} !== 6'b0) begin
      bad++; $display("FAIL reset_handshake got=%b want=000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err});
    end
    total++;
    if ({i_rdata, d_rdata} !== '0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", i_rdata, d_rdata);
    end
    total++;
    if ({m_req, m_we, m_addr, m_wdata, m_be} !== '0) begin
      bad++; $display("FAIL reset_mem_side got req=%b we=%b addr=%h be=%h want all 0", m_req, m_we, m_addr, m_be);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_simultaneous();
    bit ok;
    resp_t e, o;
    mreq_t me, mo;
    clear_logs();
    gnt_delay = 0; resp_delay = 1;
    push_i(64'h100);
    push_d(1'b1, 64'h200, 64'h1122, 8'h0F);
    push_i(64'h108);
    push_d(1'b1, 64'h208, 64'h1122, 8'h0F);
    drain(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL simul_drain got=timeout want=complete"); end
    total++;
    if (gnt_port.size() != 4) begin
      bad++; $display("FAIL simul_gnt_count got=%0d want=4", gnt_port.size());
    end
    for (int k = 0; k < 4 && k < gnt_port.size(); k++) begin
      total++;
      if (gnt_port[k] !== logic'(k % 2)) begin
        bad++; $display("FAIL simul_order[%0d] got=%0d want=%0d", k, gnt_port[k], k % 2);
      end
      if (k > 0) begin
        total++;
        if (gnt_cyc[k] - gnt_cyc[k-1] != 3) begin
          bad++; $display("FAIL simul_b2b_spacing[%0d] got=%0d want=3", k, gnt_cyc[k] - gnt_cyc[k-1]);
        end
      end
    end
    while (mexp_q.size() > 0 && mobs_q.size() > 0) begin
      me = mexp_q.pop_front(); mo = mobs_q.pop_front();
      total++;
      if (mo.we !== me.we || mo.addr !== me.addr || mo.be !== me.be || (me.we && mo.wdata !== me.wdata)) begin
        bad++; $display("FAIL simul_mreq got we=%b addr=%h wd=%h be=%h want we=%b addr=%h wd=%h be=%h",
                        mo.we, mo.addr, mo.wdata, mo.be, me.we, me.addr, me.wdata, me.be);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++; $display("FAIL simul_rsp got port=%0d err=%0d data=%h want port=%0d err=%0d data=%h",
                        o.port, o.err, o.data, e.port, e.err, e.data);
      end
    end
  endtask

  task automatic test_single_fetch();
    bit ok;
    resp_t o;
    mreq_t mo;
    clear_logs();
    gnt_delay = 0; resp_delay = 1;
    push_i(64'h40);
    drain(50, ok);
    total++;
    if (!ok || obs_q.size() != 1 || gnt_port.size() != 1) begin
      bad++; $display("FAIL fetch_counts got ok=%0d rsp=%0d gnt=%0d want 1/1/1", ok, obs_q.size(), gnt_port.size());
    end else begin
      total++;
      if (gnt_port[0] !== 1'b0) begin bad++; $display("FAIL fetch_gnt_port got=%0d want=0", gnt_port[0]); end
      total++;
      if (obs_cyc[0] - gnt_cyc[0] != 2) begin
        bad++; $display("FAIL fetch_latency got=%0d want=2", obs_cyc[0] - gnt_cyc[0]);
      end
      o = obs_q.pop_front();
      total++;
      if (o !== resp_t'({1'b0, 1'b0, 64'hDEAD})) begin
        bad++; $display("FAIL fetch_rsp got port=%0d err=%0d data=%h want port=0 err=0 data=dead", o.port, o.err, o.data);
      end
      mo = mobs_q.pop_front();
      total++;
      if (mo.we !== 1'b0 || mo.addr !== 64'h40 || mo.be !== 8'hFF) begin
        bad++; $display("FAIL fetch_mreq got we=%b addr=%h be=%h want we=0 addr=40 be=ff", mo.we, mo.addr, mo.be);
      end
    end
  endtask

  task automatic test_store_during_fetch();
    bit ok;
    resp_t e, o;
    clear_logs();
    gnt_delay = 0; resp_delay = 4;
    push_i(64'h300);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #3;
      if (gnt_port.size() > 0) break;
    end
    repeat (2) @(negedge clk);
    push_d(1'b1, 64'h380, 64'hCAFE_F00D, 8'hF0);
    drain(60, ok);
    total++;
    if (!ok || gnt_port.size() != 2 || obs_q.size() != 2) begin
      bad++; $display("FAIL store_wait_counts got ok=%0d gnt=%0d rsp=%0d want 1/2/2", ok, gnt_port.size(), obs_q.size());
    end else begin
      total++;
      if (gnt_port[1] !== 1'b1 || gnt_cyc[1] != obs_cyc[0] + 1) begin
        bad++; $display("FAIL store_wait_gnt got port=%0d cyc=%0d want port=1 cyc=%0d", gnt_port[1], gnt_cyc[1], obs_cyc[0] + 1);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        total++;
        if (o !== e) begin
          bad++; $display("FAIL store_wait_rsp got port=%0d err=%0d data=%h want port=%0d err=%0d data=%h",
                          o.port, o.err, o.data, e.port, e.err, e.data);
        end
      end
    end
    resp_delay = 1;
  endtask

  task automatic test_timeout();
    bit ok;
    resp_t o;
    clear_logs();
    gnt_delay = 0; resp_delay = 1; withhold = 1'b1;
    iq.push_back(64'h500);
    exp_q.push_back({1'b0, 1'b1, {DW{1'b0}}});
    drain(60, ok);
    total++;
    if (!ok || obs_q.size() != 1 || gnt_cyc.size() != 1) begin
      bad++; $display("FAIL timeout_counts got ok=%0d rsp=%0d want 1/1", ok, obs_q.size());
    end else begin
      total++;
      if (obs_cyc[0] - gnt_cyc[0] != TO + 1) begin
        bad++; $display("FAIL timeout_cycle got=%0d want=%0d", obs_cyc[0] - gnt_cyc[0], TO + 1);
      end
      o = obs_q.pop_front();
      total++;
      if (o !== exp_q[0]) begin
        bad++; $display("FAIL timeout_rsp got port=%0d err=%0d data=%h want port=0 err=1 data=0", o.port, o.err, o.data);
      end
    end
    withhold = 1'b0;
    inject_rv = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL late_rvalid_ignored got=%0d responses want=0", obs_q.size());
    end
  endtask

  task automatic test_stall_and_same_cycle();
    bit ok;
    resp_t e, o;
    mreq_t mo;
    clear_logs();
    unstable = 0;
    gnt_delay = 5; resp_delay = 1;
    push_d(1'b0, 64'h600, 64'h0, 8'hF0);
    drain(60, ok);
    total++;
    if (!ok || obs_q.size() != 1) begin
      bad++; $display("FAIL stall_counts got ok=%0d rsp=%0d want 1/1", ok, obs_q.size());
    end else begin
      total++;
      if (unstable != 0 || obs_cyc[0] - gnt_cyc[0] != 7) begin
        bad++; $display("FAIL stall_hold got unstable=%0d latency=%0d want 0/7", unstable, obs_cyc[0] - gnt_cyc[0]);
      end
      e = exp_q.pop_front(); o = obs_q.pop_front(); mo = mobs_q.pop_front();
      total++;
      if (o !== e || mo.we !== 1'b0 || mo.be !== 8'hF0 || mo.addr !== 64'h600) begin
        bad++; $display("FAIL stall_rsp got data=%h port=%0d be=%h want data=%h port=1 be=f0", o.data, o.port, mo.be, e.data);
      end
    end
    clear_logs();
    gnt_delay = 0; resp_delay = 0;
    push_i(64'h700);
    push_i(64'h708);
    drain(40, ok);
    total++;
    if (!ok || obs_q.size() != 2 || gnt_cyc.size() != 2) begin
      bad++; $display("FAIL same_cycle_counts got ok=%0d rsp=%0d gnt=%0d want 1/2/2", ok, obs_q.size(), gnt_cyc.size());
    end else begin
      total++;
      if (obs_cyc[0] - gnt_cyc[0] != 1 || gnt_cyc[1] - gnt_cyc[0] != 2) begin
        bad++; $display("FAIL same_cycle_timing got rsp=%0d regnt=%0d want 1/2", obs_cyc[0] - gnt_cyc[0], gnt_cyc[1] - gnt_cyc[0]);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        total++;
        if (o !== e) begin
          bad++; $display("FAIL same_cycle_rsp got data=%h err=%0d want data=%h err=%0d", o.data, o.err, e.data, e.err);
        end
      end
    end
    resp_delay = 1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    resp_t e, o;
    clear_logs();
    gnt_delay = 0; resp_delay = 8;
    iq.push_back(64'h800);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #3;
      if (gnt_port.size() > 0) break;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if ({m_req, m_addr, m_be, i_rvalid, i_gnt, d_gnt} !== '0) begin
      bad++; $display("FAIL reset_mid_outputs got req=%b addr=%h be=%h rv=%b want all 0", m_req, m_addr, m_be, i_rvalid);
    end
    clear_logs();
    resp_delay = 1;
    push_i(64'h900);
    push_d(1'b1, 64'hA00, 64'h55AA, 8'h3C);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (i_req !== 1'b1 || d_req !== 1'b1 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
      bad++; $display("FAIL reset_hold_gnt got req=%b%b gnt=%b%b want req=11 gnt=00", i_req, d_req, i_gnt, d_gnt);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    drain(60, ok);
    total++;
    if (!ok || gnt_port.size() != 2 || obs_q.size() != 2) begin
      bad++; $display("FAIL reset_mid_counts got ok=%0d gnt=%0d rsp=%0d want 1/2/2", ok, gnt_port.size(), obs_q.size());
    end else begin
      total++;
      if (gnt_port[0] !== 1'b0) begin
        bad++; $display("FAIL reset_first_gnt got port=%0d want=0", gnt_port[0]);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        total++;
        if (o !== e) begin
          bad++; $display("FAIL reset_mid_rsp got port=%0d data=%h want port=%0d data=%h", o.port, o.data, e.port, e.data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single_fetch();
    test_store_during_fetch();
    test_timeout();
    test_stall_and_same_cycle();
    test_reset_mid();
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL protocol_violations got=%0d want=0", viol);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
